// File: rtl/mem_op_sequencer_if.sv
// Command and memory-bus bundle for mem_op_sequencer.
// The master side is the environment (command issuer plus memory); the slave side is the sequencer.
interface mem_op_sequencer_if #(
    parameter int SIZE     = 5,
    parameter int MEM_SIZE = 25
);
    logic                start;
    logic [1:0]          op;
    logic [MEM_SIZE-1:0] line_in;
    logic [SIZE-1:0]     rot_amt;
    logic                busy;
    logic                done;
    logic [MEM_SIZE-1:0] line_out;
    logic                line_valid;
    logic                mismatch;
    logic                mem_init;
    logic [MEM_SIZE-1:0] mem_line;
    logic [SIZE-1:0]     mem_index;
    logic                mem_val;
    logic                mem_write;
    logic                mem_read;
    logic                mem_out;

    modport master (
        output start, op, line_in, rot_amt, mem_out,
        input  busy, done, line_out, line_valid, mismatch,
        input  mem_init, mem_line, mem_index, mem_val, mem_write, mem_read
    );

    modport slave (
        input  start, op, line_in, rot_amt, mem_out,
        output busy, done, line_out, line_valid, mismatch,
        output mem_init, mem_line, mem_index, mem_val, mem_write, mem_read
    );
endinterface

// File: rtl/mem_op_sequencer.sv
// Bit-serial LOAD/DUMP/ROTATE/CLEAR sequencer for a single-bit-access memory.
// Optional read-back verify pass after ROTATE/CLEAR: define MEM_OP_SEQUENCER_VERIFY_EN.
module mem_op_sequencer #(
    parameter int SIZE     = 5,
    parameter int MEM_SIZE = 25
) (
    input  logic               clk,
    input  logic               rst,
    mem_op_sequencer_if.slave  bus
);
    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_DUMP   = 2'b01;
    localparam logic [1:0] OP_ROTATE = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;
    localparam logic [SIZE-1:0] LAST_IDX = SIZE'(MEM_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READ,
        S_WRITE,
        S_DONE
`ifdef MEM_OP_SEQUENCER_VERIFY_EN
        , S_VERIFY
`endif
    } state_t;

    state_t              state_reg, state_next;
    logic [SIZE-1:0]     cnt_reg, cnt_next;
    logic [MEM_SIZE-1:0] shadow_reg, shadow_next;
    logic [1:0]          op_reg;
    logic [SIZE-1:0]     rot_reg;
    logic [MEM_SIZE-1:0] line_reg;
    logic [MEM_SIZE-1:0] line_out_reg, line_out_next;
`ifdef MEM_OP_SEQUENCER_VERIFY_EN
    logic                mismatch_reg, mismatch_next;
`endif

    logic                  accept;
    logic                  is_last;
    logic [SIZE-1:0]       cnt_inc;
    logic [SIZE-1:0]       rot_mod;
    logic [MEM_SIZE-1:0]   hit;
    logic [2*MEM_SIZE-1:0] rot_dbl;
    logic [MEM_SIZE-1:0]   rotated;
    logic                  write_bit;

    logic                mem_init_c, mem_val_c, mem_write_c, mem_read_c;
    logic [MEM_SIZE-1:0] mem_line_c;
    logic [SIZE-1:0]     mem_index_c;

    assign accept  = (state_reg == S_IDLE) && bus.start;
    assign is_last = (cnt_reg == LAST_IDX);
    assign cnt_inc = is_last ? '0 : cnt_reg + SIZE'(1);
    assign rot_mod = SIZE'(32'(bus.rot_amt) % MEM_SIZE);

    // One-hot decode of the counter so bit selects stay within the vector for any SIZE/MEM_SIZE.
    genvar gi;
    generate
        for (gi = 0; gi < MEM_SIZE; gi++) begin : g_hit
            assign hit[gi] = (cnt_reg == SIZE'(gi));
        end
    endgenerate

    // Upper half of the doubled image is the shadow rotated toward higher indices.
    assign rot_dbl   = {shadow_reg, shadow_reg} << rot_reg;
    assign rotated   = rot_dbl[2*MEM_SIZE-1:MEM_SIZE];
    assign write_bit = (op_reg == OP_ROTATE) ? |(rotated & hit) : 1'b0;

    assign shadow_next = (state_reg == S_READ)
                       ? ((shadow_reg & ~hit) | (hit & {MEM_SIZE{bus.mem_out}}))
                       : shadow_reg;

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        line_out_next = line_out_reg;
`ifdef MEM_OP_SEQUENCER_VERIFY_EN
        mismatch_next = mismatch_reg;
`endif
        mem_init_c    = 1'b0;
        mem_line_c    = '0;
        mem_index_c   = '0;
        mem_val_c     = 1'b0;
        mem_write_c   = 1'b0;
        mem_read_c    = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (bus.start) begin
                    cnt_next = '0;
`ifdef MEM_OP_SEQUENCER_VERIFY_EN
                    mismatch_next = 1'b0;
`endif
                    case (bus.op)
                        OP_LOAD:  state_next = S_LOAD;
                        OP_CLEAR: state_next = S_WRITE;
                        default:  state_next = S_READ;
                    endcase
                end
            end
            S_LOAD: begin
                mem_init_c = 1'b1;
                mem_line_c = line_reg;
                state_next = S_DONE;
            end
            S_READ: begin
                mem_read_c  = 1'b1;
                mem_index_c = cnt_reg;
                cnt_next    = cnt_inc;
                if (is_last) begin
                    if (op_reg == OP_DUMP) begin
                        state_next    = S_DONE;
                        line_out_next = shadow_next;
                    end else begin
                        state_next = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                mem_write_c = 1'b1;
                mem_index_c = cnt_reg;
                mem_val_c   = write_bit;
                cnt_next    = cnt_inc;
                if (is_last) begin
`ifdef MEM_OP_SEQUENCER_VERIFY_EN
                    state_next = S_VERIFY;
`else
                    state_next = S_DONE;
`endif
                end
            end
`ifdef MEM_OP_SEQUENCER_VERIFY_EN
            // Expected bit is exactly what the write pass stored at this index.
            S_VERIFY: begin
                mem_read_c  = 1'b1;
                mem_index_c = cnt_reg;
                cnt_next    = cnt_inc;
                if (bus.mem_out != write_bit) mismatch_next = 1'b1;
                if (is_last) state_next = S_DONE;
            end
`endif
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            shadow_reg   <= '0;
            op_reg       <= '0;
            rot_reg      <= '0;
            line_reg     <= '0;
            line_out_reg <= '0;
`ifdef MEM_OP_SEQUENCER_VERIFY_EN
            mismatch_reg <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            shadow_reg   <= shadow_next;
            line_out_reg <= line_out_next;
`ifdef MEM_OP_SEQUENCER_VERIFY_EN
            mismatch_reg <= mismatch_next;
`endif
            if (accept) begin
                op_reg   <= bus.op;
                rot_reg  <= rot_mod;
                line_reg <= bus.line_in;
            end
        end
    end

    assign bus.busy       = (state_reg != S_IDLE);
    assign bus.done       = (state_reg == S_DONE);
    assign bus.line_valid = (state_reg == S_DONE) && (op_reg == OP_DUMP);
    assign bus.line_out   = line_out_reg;
`ifdef MEM_OP_SEQUENCER_VERIFY_EN
    assign bus.mismatch   = mismatch_reg;
`else
    assign bus.mismatch   = 1'b0;
`endif
    assign bus.mem_init   = mem_init_c;
    assign bus.mem_line   = mem_line_c;
    assign bus.mem_index  = mem_index_c;
    assign bus.mem_val    = mem_val_c;
    assign bus.mem_write  = mem_write_c;
    assign bus.mem_read   = mem_read_c;
endmodule

// File: tb/tb_mem_op_sequencer.sv
// Scoreboard bench for mem_op_sequencer with a behavioural 25-bit memory.
module tb_mem_op_sequencer;
    localparam int SIZE     = 5;
    localparam int MEM_SIZE = 25;
`ifdef MEM_OP_SEQUENCER_VERIFY_EN
    localparam int VPASS = 25;
`else
    localparam int VPASS = 0;
`endif
    localparam logic [1:0] OP_LOAD = 2'b00, OP_DUMP = 2'b01, OP_ROTATE = 2'b10, OP_CLEAR = 2'b11;

    typedef struct {
        string      name;
        logic [1:0] op;
        logic [24:0] line;
        logic       mism;
        int         lat;
        int         n_init;
        int         n_read;
        int         n_write;
        int         start_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_op_sequencer_if #(.SIZE(SIZE), .MEM_SIZE(MEM_SIZE)) bus ();
    mem_op_sequencer #(.SIZE(SIZE), .MEM_SIZE(MEM_SIZE)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [MEM_SIZE-1:0] mem_q;
    bit   fault_en = 1'b0;
    int   fault_idx = 3;

    always @(posedge clk) begin
        if (bus.mem_init)  mem_q <= bus.mem_line;
        if (bus.mem_write) mem_q[bus.mem_index] <= bus.mem_val;
    end
    assign bus.mem_out = (bus.mem_read && !(fault_en && int'(bus.mem_index) == fault_idx))
                       ? mem_q[bus.mem_index] : 1'b0;

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   n_init, n_read, n_write, n_busy;
    bit   idx_bad;
    exp_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end else begin
            $display("[TB] ok %s = %0h", name, got);
        end
    endtask

    // Monitor: accumulates strobe activity and scores each done pulse against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.busy)     n_busy++;
            if (bus.mem_init) n_init++;
            if (bus.mem_read) begin
                if (bus.mem_index != SIZE'(n_read % MEM_SIZE)) idx_bad = 1'b1;
                n_read++;
            end
            if (bus.mem_write) begin
                if (bus.mem_index != SIZE'(n_write % MEM_SIZE)) idx_bad = 1'b1;
                n_write++;
            end
            if (bus.line_valid && !bus.done) check("line_valid_without_done", 1, 0);
            if (bus.done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_latency"}, 64'(cyc - e.start_cyc), 64'(e.lat));
                    check({e.name, "_busy_cycles"}, 64'(n_busy), 64'(e.lat));
                    check({e.name, "_line_valid"}, 64'(bus.line_valid), 64'(e.op == OP_DUMP));
                    if (e.op == OP_DUMP) check({e.name, "_line_out"}, 64'(bus.line_out), 64'(e.line));
                    check({e.name, "_mismatch"}, 64'(bus.mismatch), 64'(e.mism));
                    check({e.name, "_init_cycles"}, 64'(n_init), 64'(e.n_init));
                    check({e.name, "_read_cycles"}, 64'(n_read), 64'(e.n_read));
                    check({e.name, "_write_cycles"}, 64'(n_write), 64'(e.n_write));
                    check({e.name, "_index_order_bad"}, 64'(idx_bad), 64'(0));
                end
            end
        end
    end

    task automatic issue(input string name, input logic [1:0] op, input logic [24:0] line,
                         input logic [4:0] rot, input logic [24:0] exp_line, input logic exp_mism,
                         input bit inject, input bit fault);
        exp_t e;
        bit   ok;
        e.name = name; e.op = op; e.line = exp_line; e.mism = exp_mism;
        e.n_init = 0; e.n_read = 0; e.n_write = 0;
        case (op)
            OP_LOAD:   begin e.lat = 2;              e.n_init = 1; end
            OP_DUMP:   begin e.lat = 26;             e.n_read = 25; end
            OP_ROTATE: begin e.lat = 51 + VPASS;     e.n_read = 25 + VPASS; e.n_write = 25; end
            default:   begin e.lat = 26 + VPASS;     e.n_read = VPASS; e.n_write = 25; end
        endcase
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = op; bus.line_in = line; bus.rot_amt = rot;
        n_init = 0; n_read = 0; n_write = 0; n_busy = 0; idx_bad = 1'b0;
        e.start_cyc = cyc;
        sb.push_back(e);
        @(posedge clk); #1;
        bus.start = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (inject && k == 10) begin bus.start = 1'b1; bus.op = OP_CLEAR; end
            else if (inject && k == 11) bus.start = 1'b0;
            if (fault && n_write == MEM_SIZE) fault_en = 1'b1;
            if (sb.size() == 0) begin ok = 1'b1; break; end
        end
        bus.start = 1'b0;
        fault_en  = 1'b0;
        if (!ok) begin
            check({name, "_timeout"}, 0, 1);
            sb.delete();
        end
    endtask

    initial begin
        bit seen;
        bus.start = 1'b0; bus.op = 2'b00; bus.line_in = '0; bus.rot_amt = '0;
        n_init = 0; n_read = 0; n_write = 0; n_busy = 0; idx_bad = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              64'({bus.busy, bus.done, bus.line_valid, bus.mismatch, bus.line_out, bus.mem_init,
                   bus.mem_line, bus.mem_index, bus.mem_val, bus.mem_write, bus.mem_read}), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        issue("load_1", OP_LOAD, 25'h0000001, 5'd0, 25'h0, 1'b0, 1'b0, 1'b0);

        // DUMP aborted by rst at READ index 10: no done, back to IDLE.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = OP_DUMP;
        @(posedge clk); #1;
        bus.start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (bus.mem_read && bus.mem_index == 5'd10) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        check("rst_mid_reached_idx10", 64'(seen), 64'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", 64'(bus.busy), 64'(0));
        check("rst_mid_done", 64'(bus.done), 64'(0));
        check("rst_mid_line_out", 64'(bus.line_out), 64'(0));
        repeat (40) @(posedge clk);

        issue("dump_after_rst", OP_DUMP, 25'h0, 5'd0, 25'h0000001, 1'b0, 1'b0, 1'b0);
        issue("load_5555", OP_LOAD, 25'h1555555, 5'd0, 25'h0, 1'b0, 1'b0, 1'b0);
        issue("dump_5555_ignored_start", OP_DUMP, 25'h0, 5'd0, 25'h1555555, 1'b0, 1'b1, 1'b0);
        issue("dump_5555_again", OP_DUMP, 25'h0, 5'd0, 25'h1555555, 1'b0, 1'b0, 1'b0);

        issue("load_rot3", OP_LOAD, 25'h0000001, 5'd0, 25'h0, 1'b0, 1'b0, 1'b0);
        issue("rot3", OP_ROTATE, 25'h0, 5'd3, 25'h0, 1'b0, 1'b0, 1'b0);
        issue("dump_rot3", OP_DUMP, 25'h0, 5'd0, 25'h0000008, 1'b0, 1'b0, 1'b0);

        issue("load_wrap", OP_LOAD, 25'h1000000, 5'd0, 25'h0, 1'b0, 1'b0, 1'b0);
        issue("rot1", OP_ROTATE, 25'h0, 5'd1, 25'h0, 1'b0, 1'b0, 1'b0);
        issue("dump_rot1_wrap", OP_DUMP, 25'h0, 5'd0, 25'h0000001, 1'b0, 1'b0, 1'b0);

        issue("load_rot27", OP_LOAD, 25'h0000001, 5'd0, 25'h0, 1'b0, 1'b0, 1'b0);
        issue("rot27", OP_ROTATE, 25'h0, 5'd27, 25'h0, 1'b0, 1'b0, 1'b0);
        issue("dump_rot27", OP_DUMP, 25'h0, 5'd0, 25'h0000004, 1'b0, 1'b0, 1'b0);

        issue("load_rot0", OP_LOAD, 25'h1234567, 5'd0, 25'h0, 1'b0, 1'b0, 1'b0);
        issue("rot0", OP_ROTATE, 25'h0, 5'd0, 25'h0, 1'b0, 1'b0, 1'b0);
        issue("dump_rot0", OP_DUMP, 25'h0, 5'd0, 25'h1234567, 1'b0, 1'b0, 1'b0);

        issue("load_ones", OP_LOAD, 25'h1FFFFFF, 5'd0, 25'h0, 1'b0, 1'b0, 1'b0);
        issue("clear", OP_CLEAR, 25'h0, 5'd0, 25'h0, 1'b0, 1'b0, 1'b0);
        issue("dump_clear", OP_DUMP, 25'h0, 5'd0, 25'h0000000, 1'b0, 1'b0, 1'b0);

`ifdef MEM_OP_SEQUENCER_VERIFY_EN
        issue("load_verify", OP_LOAD, 25'h0000001, 5'd0, 25'h0, 1'b0, 1'b0, 1'b0);
        issue("rot3_fault", OP_ROTATE, 25'h0, 5'd3, 25'h0, 1'b1, 1'b0, 1'b1);
        issue("load_clears_mismatch", OP_LOAD, 25'h0000001, 5'd0, 25'h0, 1'b0, 1'b0, 1'b0);
`endif

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1);
    end
endmodule

// File: doc/mem_op_sequencer.md
Name: mem_op_sequencer

Overview:
- Controller for the 25-bit bit-addressable memory block (5-bit index, init/line load, single-bit read/write).
- Accepts one command at a time through a start/busy/done handshake: LOAD, DUMP, ROTATE or CLEAR.
- Drives the memory's init, line, index, val, write and read strobes, one bit per cycle.
- Sits between the top-level FSM and the memory block; the memory sees no other master.

Parameters:
- SIZE, 5, index width.
- MEM_SIZE, 25, number of memory bits; legal range 2..2^SIZE.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  command request; sampled only in IDLE.
- op  input  2  command: 00 LOAD, 01 DUMP, 10 ROTATE, 11 CLEAR.
- line_in  input  MEM_SIZE  LOAD data.
- rot_amt  input  SIZE  ROTATE amount.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- line_out  output  MEM_SIZE  memory image captured by DUMP.
- line_valid  output  1  one-cycle pulse coincident with done after DUMP.
- mismatch  output  1  verify failure flag (see Optional Feature).
- mem_init  output  1  memory init strobe.
- mem_line  output  MEM_SIZE  memory init data.
- mem_index  output  SIZE  memory bit index.
- mem_val  output  1  memory write data.
- mem_write  output  1  memory write strobe.
- mem_read  output  1  memory read strobe.
- mem_out  input  1  memory read data.

Behaviour:
- Interface: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: state IDLE, counter 0, shadow register 0, latched op/rot 0, line_out 0, mismatch 0. busy, done, line_valid and all mem_* outputs are 0.
- States: IDLE, LOAD, READ, WRITE, DONE. Memory strobes are decoded combinationally from state; all are 0 in IDLE and DONE.
- IDLE: start=1 latches op, line_in and (rot_amt mod MEM_SIZE), and clears the counter.
  - Next state: LOAD for 00, READ for 01/10, WRITE for 11.
  - start while busy is ignored; no queueing.
- LOAD: one cycle with mem_init=1 and mem_line=latched line_in, then DONE. Done appears 2 cycles after the start edge.
- READ: mem_read=1 and mem_index=counter.
  - Each edge: shadow[counter] <= mem_out, counter increments.
  - After index MEM_SIZE-1, the counter clears.
  - Next: DONE for DUMP (line_out <= shadow at the same edge); WRITE for ROTATE.
- WRITE: mem_write=1 and mem_index=counter, counter increments each edge.
  - CLEAR: mem_val=0.
  - ROTATE: mem_val = shadow[(counter + MEM_SIZE - rot) mod MEM_SIZE], i.e. bits move toward higher index and wrap.
  - After index MEM_SIZE-1, go to DONE.
- DONE: done=1 for one cycle (line_valid=1 too if op was DUMP), then IDLE. A new start is accepted the cycle after DONE.
- Latency from start edge to done cycle: LOAD 2, DUMP 26, CLEAR 26, ROTATE 51.
- Boundaries:
  - rot=0 rewrites identical data.
  - rot_amt>=MEM_SIZE is reduced modulo MEM_SIZE.
  - The index never exceeds MEM_SIZE-1.
  - Counter wrap is exact at MEM_SIZE-1.
- line_out holds its value until the next DUMP completes or rst.
- rst mid-operation: returns to IDLE at that edge with no done pulse. A strobe driven during the rst cycle still reaches the memory at that edge. Memory contents are otherwise untouched.

Optional Feature:
- Macro: MEM_OP_SEQUENCER_VERIFY_EN.
- Defined: ROTATE and CLEAR add a VERIFY state after WRITE. VERIFY makes a full read pass comparing mem_out with the expected bit.
  - Any difference sets mismatch, sticky until the next accepted start or rst.
  - ROTATE/CLEAR latency grows by MEM_SIZE: 76 and 51.
- Undefined: no VERIFY state; mismatch is tied to 0. Latencies are as in Behaviour.

Test Plan:
- rst, then LOAD line_in=25'h0000001 -> mem_init high for exactly 1 cycle, done at +2, busy high over that span.
- LOAD 25'h1555555, then DUMP -> mem_read asserted for 25 cycles with index 0..24, done+line_valid at +26, line_out=25'h1555555.
- LOAD 25'h0000001, ROTATE rot_amt=3, DUMP -> line_out=25'h0000008. Repeat with 25'h1000000, rot=1 -> 25'h0000001 (wrap).
- ROTATE rot_amt=27 on 25'h0000001 -> same as rot=2: 25'h0000004. CLEAR on 25'h1FFFFFF -> DUMP gives 0, CLEAR done at +26.
- Pulse start with op=11 while a DUMP is running -> ignored; only one done. rst asserted at READ index 10 -> IDLE next cycle, busy=0, no done, line_out unchanged.
- With MEM_OP_SEQUENCER_VERIFY_EN: force mem_out low at one verify index after ROTATE -> mismatch=1, done at +76. The next start clears mismatch.
